cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Synthesisable run controller for the single-cycle/pipelined CPU; replaces hand-timed PC-load and clock-enable stimulus with a hardware sequencer.
- On a start request it loads a boot PC, holds the core for a settle interval, then enables execution.
- It counts executed cycles and stops the core on a cycle limit or on detected halt (PC stuck).
- Sits between bench/top-level control and the cpu's pc_ld, pc_data and clock-enable inputs.

Parameters:
ADDR_W, 32, PC width
DEFAULT_PC, 32'h0040_0020, boot address used when use_boot_addr=0
SETTLE_CYCLES, 2, cycles between pc_ld pulse and cpu_en rising (>=1)
CNT_W, 32, cycle counter width
MAX_CYCLES, 160, cycle limit used when cycle_limit=0
HALT_REPEAT, 4, consecutive unchanged-PC samples that declare halt; 0 disables halt detection

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled in IDLE or DONE only
abort  in  1  force return to IDLE from any state
use_boot_addr  in  1  1: use boot_addr, 0: use DEFAULT_PC
boot_addr  in  ADDR_W  external boot PC
cycle_limit  in  CNT_W  run-cycle limit; 0 selects MAX_CYCLES
pc  in  ADDR_W  current PC from cpu
pc_ld  out  1  one-cycle PC load strobe to cpu
pc_data  out  ADDR_W  PC value to load
cpu_en  out  1  cpu execution enable
busy  out  1  high in LOAD, SETTLE, RUN
done  out  1  high in DONE
halted  out  1  run ended by halt detection
timeout  out  1  run ended by cycle limit
cycle_count  out  CNT_W  cycles executed with cpu_en=1 in the current/last run

Behaviour:
- Reset (async, rst_n=0) sets state=IDLE and all outputs to 0; pc_data=0.
- All outputs are registered.
- IDLE: start=1 at edge N latches the address (boot_addr or DEFAULT_PC) into pc_data and latches the limit (cycle_limit, or MAX_CYCLES if 0). It also clears cycle_count, halted and timeout, and goes to LOAD.
- LOAD: pc_ld=1 for exactly one cycle (N..N+1). busy=1. Next state is SETTLE.
- SETTLE: cpu_en=0 for SETTLE_CYCLES cycles. cpu_en rises at edge N+1+SETTLE_CYCLES, entering RUN.
- RUN: cpu_en=1. cycle_count increments on each edge while in RUN. At the edge where cycle_count would reach the limit, go to DONE with timeout=1; the core sees exactly limit cycles with cpu_en=1.
- Halt detection, active only in RUN and only when HALT_REPEAT>0:
  - pc is compared with pc captured on the previous RUN edge; the first RUN edge only captures.
  - The repeat counter increments on a match and clears on a mismatch.
  - When the counter reaches HALT_REPEAT, go to DONE with halted=1.
- Simultaneous halt and limit on the same edge: halted=1, timeout=0.
- DONE: cpu_en=0, busy=0, done=1. cycle_count, halted and timeout hold until the next start. start in DONE behaves as in IDLE (restart); done drops as LOAD is entered.
- start while busy: ignored.
- abort (any state, highest priority after reset):
  - Next edge goes to IDLE with cpu_en=0, pc_ld=0, done=0.
  - halted and timeout are cleared; cycle_count holds.
- pc_data holds its latched value until the next accepted start.
- Reset mid-run: immediate async clear; cpu_en drops without waiting for a clock edge.
- Counters saturate-free. The limit must be less than 2^CNT_W; cycle_count never wraps within a legal limit.

Test Plan:
- Reset then start=1 for 1 cycle, use_boot_addr=0, cycle_limit=0, pc incrementing by 4 each cycle -> pc_ld high exactly 1 cycle with pc_data=0x00400020; cpu_en rises 2 cycles later; cpu_en high exactly 160 cycles; done=1, timeout=1, cycle_count=160.
- use_boot_addr=1, boot_addr=0x00001000, cycle_limit=50, pc increments 10 cycles then freezes -> halted=1, timeout=0 after 4 matching samples; cycle_count=15 (the first RUN edge only captures pc, so 10 changing cycles plus 1 capture plus 4 matches); cpu_en low in DONE.
- Halt and limit coincide (cycle_limit chosen so the 4th matching sample lands on the limit edge) -> halted=1, timeout=0.
- abort asserted mid-RUN at cycle 20 -> next edge IDLE, cpu_en=0, done=0, cycle_count holds 20; later start restarts cleanly from LOAD.
- start pulsed during SETTLE and RUN -> ignored, no second pc_ld; start in DONE -> new run, flags cleared, cycle_count restarts at 0.
- rst_n pulled low asynchronously mid-RUN (between clock edges) -> cpu_en, busy and all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Control/CPU-side signal bundle for cpu_run_ctrl. The master is the top-level/bench
// control plus the cpu's PC report; the slave is the run controller itself.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  // Handshake: start is a level request sampled only in IDLE or DONE; busy going high
  // is the acceptance. abort may be asserted at any time and is acted on at the next edge.
  logic              start;
  logic              abort;
  logic              use_boot_addr;
  logic [ADDR_W-1:0] boot_addr;
  logic [CNT_W-1:0]  cycle_limit;
  logic [ADDR_W-1:0] pc;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_data;
  logic              cpu_en;
  logic              busy;
  logic              done;
  logic              halted;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, abort, use_boot_addr, boot_addr, cycle_limit, pc,
    input  pc_ld, pc_data, cpu_en, busy, done, halted, timeout, cycle_count
  );

  modport slave (
    input  start, abort, use_boot_addr, boot_addr, cycle_limit, pc,
    output pc_ld, pc_data, cpu_en, busy, done, halted, timeout, cycle_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the cpu: loads a boot PC, waits a settle interval, enables execution,
// then stops on a cycle limit or when the PC stays unchanged for HALT_REPEAT samples.
module cpu_run_ctrl #(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] DEFAULT_PC    = 32'h0040_0020,
  parameter int                SETTLE_CYCLES = 2,
  parameter int                CNT_W         = 32,
  parameter int                MAX_CYCLES    = 160,
  parameter int                HALT_REPEAT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_run_ctrl_if.slave        bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;

  localparam int  SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam bit  HALT_EN  = (HALT_REPEAT > 0);
  localparam int  REP_W    = HALT_EN ? $clog2(HALT_REPEAT + 1) : 1;
  localparam int  REP_LAST = HALT_EN ? HALT_REPEAT - 1 : 0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_data_q, pc_data_nxt;
  logic [CNT_W-1:0]  limit_q, limit_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt, count_inc;
  logic [SET_W-1:0]  settle_q, settle_nxt;
  logic [REP_W-1:0]  rep_q, rep_nxt;
  logic [ADDR_W-1:0] last_pc_q, last_pc_nxt;
  logic              pc_seen_q, pc_seen_nxt;
  logic              pc_ld_q, pc_ld_nxt;
  logic              cpu_en_q, cpu_en_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              halted_q, halted_nxt;
  logic              timeout_q, timeout_nxt;
  logic              halt_hit, limit_hit;

  assign count_inc = count_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_data_q <= '0;
      limit_q   <= '0;
      count_q   <= '0;
      settle_q  <= '0;
      rep_q     <= '0;
      last_pc_q <= '0;
      pc_seen_q <= 1'b0;
      pc_ld_q   <= 1'b0;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_data_q <= pc_data_nxt;
      limit_q   <= limit_nxt;
      count_q   <= count_nxt;
      settle_q  <= settle_nxt;
      rep_q     <= rep_nxt;
      last_pc_q <= last_pc_nxt;
      pc_seen_q <= pc_seen_nxt;
      pc_ld_q   <= pc_ld_nxt;
      cpu_en_q  <= cpu_en_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      halted_q  <= halted_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_data_nxt = pc_data_q;
    limit_nxt   = limit_q;
    count_nxt   = count_q;
    settle_nxt  = settle_q;
    rep_nxt     = rep_q;
    last_pc_nxt = last_pc_q;
    pc_seen_nxt = pc_seen_q;
    pc_ld_nxt   = 1'b0;
    cpu_en_nxt  = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    halted_nxt  = halted_q;
    timeout_nxt = timeout_q;
    halt_hit    = 1'b0;
    limit_hit   = 1'b0;

    if (bus.abort) begin
      // cycle_count is deliberately kept so the aborted run length stays visible.
      state_nxt   = IDLE;
      halted_nxt  = 1'b0;
      timeout_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_nxt = (state == DONE);
          if (bus.start) begin
            state_nxt   = LOAD;
            pc_data_nxt = bus.use_boot_addr ? bus.boot_addr : DEFAULT_PC;
            limit_nxt   = (bus.cycle_limit == '0) ? CNT_W'(MAX_CYCLES) : bus.cycle_limit;
            count_nxt   = '0;
            halted_nxt  = 1'b0;
            timeout_nxt = 1'b0;
            pc_ld_nxt   = 1'b1;
            busy_nxt    = 1'b1;
            done_nxt    = 1'b0;
          end
        end
        LOAD: begin
          state_nxt  = SETTLE;
          settle_nxt = '0;
          busy_nxt   = 1'b1;
        end
        SETTLE: begin
          busy_nxt = 1'b1;
          if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
            state_nxt   = RUN;
            cpu_en_nxt  = 1'b1;
            pc_seen_nxt = 1'b0;
            rep_nxt     = '0;
          end else begin
            settle_nxt = settle_q + SET_W'(1);
          end
        end
        RUN: begin
          busy_nxt    = 1'b1;
          cpu_en_nxt  = 1'b1;
          count_nxt   = count_inc;
          last_pc_nxt = bus.pc;
          pc_seen_nxt = 1'b1;
          // The first RUN edge has no previous sample, so it only captures pc.
          if (HALT_EN && pc_seen_q) begin
            if (bus.pc == last_pc_q) begin
              rep_nxt  = rep_q + REP_W'(1);
              halt_hit = (rep_q == REP_W'(REP_LAST));
            end else begin
              rep_nxt = '0;
            end
          end
          limit_hit = (count_inc == limit_q);
          if (halt_hit || limit_hit) begin
            state_nxt   = DONE;
            cpu_en_nxt  = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            halted_nxt  = halt_hit;
            timeout_nxt = !halt_hit;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.pc_ld       = pc_ld_q;
  assign bus.pc_data     = pc_data_q;
  assign bus.cpu_en      = cpu_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = count_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a behavioural cpu PC model, directed runs covering limit,
// halt, coincidence, abort, ignored starts, restart and async reset.
module tb_cpu_run_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  cpu_run_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .ADDR_W(ADDR_W), .DEFAULT_PC(32'h0040_0020), .SETTLE_CYCLES(2),
    .CNT_W(CNT_W), .MAX_CYCLES(160), .HALT_REPEAT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];

  int cyc, pc_ld_cnt, pc_ld_cyc, en_cnt, en_rise_cyc, steps, step_limit;
  logic en_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One cycle; the cpu model advances pc once per enabled cycle after the first,
  // which matches a cpu that steps on each rising edge it sees cpu_en high.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.pc_ld) begin
      pc_ld_cnt++;
      pc_ld_cyc = cyc;
      bus.pc = bus.pc_data;
      steps = 0;
    end else if (bus.cpu_en && en_prev && steps < step_limit) begin
      bus.pc = bus.pc + 32'd4;
      steps++;
    end
    if (bus.cpu_en) begin
      en_cnt++;
      if (!en_prev) en_rise_cyc = cyc;
    end
    en_prev = bus.cpu_en;
  endtask

  task automatic start_run(input logic use_boot, input logic [ADDR_W-1:0] addr,
                           input logic [CNT_W-1:0] limit, input int slim);
    bus.use_boot_addr = use_boot;
    bus.boot_addr     = addr;
    bus.cycle_limit   = limit;
    step_limit        = slim;
    pc_ld_cnt = 0;
    en_cnt    = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
    check(tag, bus.done, 1'b1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.use_boot_addr = 1'b0;
    bus.boot_addr = '0; bus.cycle_limit = '0; bus.pc = '0;
    cyc = 0; pc_ld_cnt = 0; pc_ld_cyc = 0; en_cnt = 0; en_rise_cyc = 0;
    steps = 0; step_limit = 0; en_prev = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc_ld", bus.pc_ld, 1'b0);
    check("rst_cpu_en", bus.cpu_en, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_flags", {bus.halted, bus.timeout}, 2'b00);
    check("rst_pc_data", bus.pc_data, 32'h0);
    check("rst_count", bus.cycle_count, 32'd0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    step();

    // Default PC, default limit, pc never repeats: timeout after 160 enabled cycles.
    exp_q.push_back(32'd160);
    start_run(1'b0, 32'h0, 32'd0, 100000);
    check("t1_pc_ld", bus.pc_ld, 1'b1);
    check("t1_busy", bus.busy, 1'b1);
    check("t1_pc_data", bus.pc_data, 32'h0040_0020);
    wait_done("t1_wait", 300);
    check("t1_pc_ld_cnt", pc_ld_cnt, 1);
    // cpu_en rises 1 + SETTLE_CYCLES edges after the pc_ld edge.
    check("t1_settle", en_rise_cyc - pc_ld_cyc, 3);
    check("t1_en_cycles", en_cnt, 160);
    check("t1_flags", {bus.halted, bus.timeout}, 2'b01);
    check("t1_count", bus.cycle_count, exp_q.pop_front());
    check("t1_idle_outs", {bus.cpu_en, bus.busy}, 2'b00);

    // Restart from DONE: boot address, limit 50, pc freezes after 10 steps -> halt at 15.
    exp_q.push_back(32'd15);
    start_run(1'b1, 32'h0000_1000, 32'd50, 10);
    check("t2_restart_flags", {bus.done, bus.halted, bus.timeout}, 3'b000);
    check("t2_restart_count", bus.cycle_count, 32'd0);
    check("t2_pc_data", bus.pc_data, 32'h0000_1000);
    wait_done("t2_wait", 100);
    check("t2_flags", {bus.halted, bus.timeout}, 2'b10);
    check("t2_count", bus.cycle_count, exp_q.pop_front());
    check("t2_cpu_en", bus.cpu_en, 1'b0);
    check("t2_pc_final", bus.pc, 32'h0000_1028);

    // Limit one short of the halt point: timeout wins at 14.
    start_run(1'b1, 32'h0000_2000, 32'd14, 10);
    wait_done("t3a_wait", 100);
    check("t3a_flags", {bus.halted, bus.timeout}, 2'b01);
    check("t3a_count", bus.cycle_count, 32'd14);

    // Limit lands on the 4th matching sample: halt takes priority.
    start_run(1'b1, 32'h0000_3000, 32'd15, 10);
    wait_done("t3b_wait", 100);
    check("t3b_flags", {bus.halted, bus.timeout}, 2'b10);
    check("t3b_count", bus.cycle_count, 32'd15);

    // Abort from DONE clears flags, keeps count.
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_done_state", dbg_state, ST_IDLE);
    check("ab_done_flags", {bus.done, bus.halted, bus.timeout}, 3'b000);
    check("ab_done_count", bus.cycle_count, 32'd15);

    // Abort mid-RUN at cycle 20.
    start_run(1'b0, 32'h0, 32'd100, 100000);
    n = 0;
    while (bus.cycle_count != 32'd20 && n < 200) begin
      step();
      n++;
    end
    check("ab_run_reach20", bus.cycle_count, 32'd20);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("ab_run_state", dbg_state, ST_IDLE);
    check("ab_run_outs", {bus.cpu_en, bus.pc_ld, bus.done, bus.busy}, 4'b0000);
    check("ab_run_count", bus.cycle_count, 32'd20);
    check("ab_run_pc_data", bus.pc_data, 32'h0040_0020);
    step();
    check("ab_run_hold", bus.cycle_count, 32'd20);

    // Clean restart after abort.
    start_run(1'b1, 32'h0000_4000, 32'd5, 100000);
    check("rs_pc_ld", bus.pc_ld, 1'b1);
    wait_done("rs_wait", 50);
    check("rs_count", bus.cycle_count, 32'd5);
    check("rs_en_cycles", en_cnt, 5);
    check("rs_flags", {bus.halted, bus.timeout}, 2'b01);

    // start pulsed in SETTLE and in RUN is ignored.
    start_run(1'b1, 32'h0000_5000, 32'd30, 100000);
    step();
    check("ig_in_settle", dbg_state, 3'd2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    check("ig_in_run", bus.cpu_en, 1'b1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("ig_wait", 100);
    check("ig_pc_ld_cnt", pc_ld_cnt, 1);
    check("ig_count", bus.cycle_count, 32'd30);
    check("ig_en_cycles", en_cnt, 30);

    // Async reset between edges mid-RUN.
    start_run(1'b0, 32'h0, 32'd100, 100000);
    repeat (12) step();
    check("ar_pre_run", {bus.cpu_en, bus.busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cpu_en", bus.cpu_en, 1'b0);
    check("ar_busy", bus.busy, 1'b0);
    check("ar_count", bus.cycle_count, 32'd0);
    check("ar_pc_data", bus.pc_data, 32'h0);
    check("ar_state", dbg_state, ST_IDLE);
    step();
    rst_n = 1'b1;
    en_prev = 1'b0;
    step();
    check("ar_after_state", dbg_state, ST_IDLE);
    check("ar_after_outs", {bus.cpu_en, bus.busy, bus.done, bus.pc_ld}, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
